// File: rtl/s2p_pkg.sv
// Shared definitions for the s2p serial link (p2s_tx transmitter and s2p receiver).
// No logic; keeping the word width here stops the two ends from drifting apart.
// Not applicable: package only.
package s2p_pkg;

    localparam int S2P_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } p2s_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered full flag.
// Latency: a pushed word is visible on rdata (empty=0) after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      wptr_nxt;
    logic [AW:0]      rptr_nxt;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] mem [DEPTH];

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign wptr_nxt = wptr + (AW+1)'(do_push);
    assign rptr_nxt = rptr + (AW+1)'(do_pop);

    // Pointers differ only in the wrap bit when every entry is occupied.
    assign empty = (wptr == rptr);
    assign rdata = mem[rptr[AW-1:0]];

    // Pointer and full-flag registers; full is precomputed from the next pointers.
    always_ff @(posedge clka) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            full <= 1'b0;
        end else begin
            wptr <= wptr_nxt;
            rptr <= rptr_nxt;
            full <= (wptr_nxt[AW] != rptr_nxt[AW]) &&
                    (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
        end
    end

    // Storage write; contents need no reset since empty guards every read.
    always_ff @(posedge clka) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: bytes become wra_n-framed MSB-first bursts for s2p.
// Latency: byte accepted into an empty FIFO while idle drives the first bit one edge later.
// Backpressure: din_ready follows !full registered; upstream holds din_valid/din until accepted.
module p2s_tx
    import s2p_pkg::*;
#(
    parameter int DW         = S2P_DW,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP        = 2
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [DW-1:0] din,
    output logic          wra_n,
    output logic          da,
    output logic          busy
);

    localparam int BW = $clog2(DW);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    s2p_pkg::p2s_state_t state_q;
    s2p_pkg::p2s_state_t state_d;

    logic [DW-1:0] shreg_q;
    logic [DW-1:0] shreg_d;
    logic [BW-1:0] bitcnt_q;
    logic [BW-1:0] bitcnt_d;
    logic [GW-1:0] gapcnt_q;
    logic [GW-1:0] gapcnt_d;
    logic          wra_n_d;
    logic          da_d;
    logic          rst_q;

    logic          fifo_push;
    logic          fifo_pop;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;

    // rst_q holds din_ready low for the cycle after a reset edge.
    assign din_ready = ~fifo_full & ~rst_q;
    assign fifo_push = din_valid & din_ready;

    // Built only from flops, so it drops on the edge the FSM returns to IDLE with nothing queued.
    assign busy = (state_q != s2p_pkg::IDLE) | ~fifo_empty;

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clka  (clka),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (din),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state logic: load a byte, shift it out MSB first, then hold the line high for GAP cycles.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        wra_n_d  = wra_n;
        da_d     = da;
        fifo_pop = 1'b0;

        case (state_q)
            s2p_pkg::IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    da_d     = fifo_rdata[DW-1];
                    wra_n_d  = 1'b0;
                    bitcnt_d = '0;
                    state_d  = s2p_pkg::SHIFT;
                end
            end
            s2p_pkg::SHIFT: begin
                if (bitcnt_q == BIT_LAST) begin
                    wra_n_d  = 1'b1;
                    da_d     = 1'b0;
                    gapcnt_d = '0;
                    state_d  = s2p_pkg::GAP;
                end else begin
                    shreg_d  = {shreg_q[DW-2:0], 1'b0};
                    da_d     = shreg_q[DW-2];
                    bitcnt_d = bitcnt_q + BW'(1);
                end
            end
            s2p_pkg::GAP: begin
                if (gapcnt_q == GAP_LAST) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                        da_d     = fifo_rdata[DW-1];
                        wra_n_d  = 1'b0;
                        bitcnt_d = '0;
                        state_d  = s2p_pkg::SHIFT;
                    end else begin
                        state_d  = s2p_pkg::IDLE;
                    end
                end else begin
                    gapcnt_d = gapcnt_q + GW'(1);
                end
            end
            default: begin
                wra_n_d = 1'b1;
                da_d    = 1'b0;
                state_d = s2p_pkg::IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset truncates any burst in flight.
    always_ff @(posedge clka) begin
        if (rst) begin
            state_q  <= s2p_pkg::IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            wra_n    <= 1'b1;
            da       <= 1'b0;
            rst_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            wra_n    <= wra_n_d;
            da       <= da_d;
            rst_q    <= 1'b0;
        end
    end

endmodule
